// File: rtl/i2q2_scheduler_pkg.sv
// Shared types for the I²+Q² scheduler: tap tags, issue FSM states and result width.
package i2q2_scheduler_pkg;

  typedef enum logic [1:0] {
    TAP_EARLY  = 2'd0,
    TAP_PROMPT = 2'd1,
    TAP_LATE   = 2'd2
  } tap_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE_E,
    S_ISSUE_P,
    S_ISSUE_L
  } state_e;

  // Sum of two unsigned squares needs one bit beyond the product width.
  function automatic int i2q2_width(input int mag_width);
    return 2 * mag_width + 1;
  endfunction

endpackage

// File: rtl/i2q2_square_pipe.sv
// Shared pipelined squarer pair with registered I²+Q² sum and a matched valid/tag delay line.
module i2q2_square_pipe
  import i2q2_scheduler_pkg::*;
#(
  parameter int MAG_WIDTH    = 18,
  parameter int MULT_LATENCY = 5,
  parameter int CH_WIDTH     = 2,
  parameter int I2Q2_WIDTH   = i2q2_width(MAG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  global_reset,
  input  logic                  in_valid,
  input  logic [CH_WIDTH-1:0]   in_channel,
  input  logic [1:0]            in_tap,
  input  logic [MAG_WIDTH-1:0]  in_i,
  input  logic [MAG_WIDTH-1:0]  in_q,
  output logic                  out_valid,
  output logic [CH_WIDTH-1:0]   out_channel,
  output logic [1:0]            out_tap,
  output logic [I2Q2_WIDTH-1:0] out_i2q2,
  output logic                  pipe_busy
);

  localparam int PROD_W = 2 * MAG_WIDTH;

  logic [PROD_W-1:0]   sq_i     [MULT_LATENCY];
  logic [PROD_W-1:0]   sq_q     [MULT_LATENCY];
  logic [CH_WIDTH-1:0] ch_pipe  [MULT_LATENCY];
  logic [1:0]          tap_pipe [MULT_LATENCY];
  logic [MULT_LATENCY-1:0] vld_pipe;

  // Squaring happens in the first stage; later stages give the multiplier room to retime.
  always_ff @(posedge clk) begin
    sq_i[0]     <= PROD_W'(in_i) * PROD_W'(in_i);
    sq_q[0]     <= PROD_W'(in_q) * PROD_W'(in_q);
    ch_pipe[0]  <= in_channel;
    tap_pipe[0] <= in_tap;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      sq_i[k]     <= sq_i[k-1];
      sq_q[k]     <= sq_q[k-1];
      ch_pipe[k]  <= ch_pipe[k-1];
      tap_pipe[k] <= tap_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      for (int k = 1; k < MULT_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_tap     <= '0;
      out_i2q2    <= '0;
    end else begin
      out_valid <= vld_pipe[MULT_LATENCY-1];
      if (vld_pipe[MULT_LATENCY-1]) begin
        out_channel <= ch_pipe[MULT_LATENCY-1];
        out_tap     <= tap_pipe[MULT_LATENCY-1];
        out_i2q2    <= I2Q2_WIDTH'(sq_i[MULT_LATENCY-1]) + I2Q2_WIDTH'(sq_q[MULT_LATENCY-1]);
      end
    end
  end

  assign pipe_busy = (|vld_pipe) || out_valid;

endmodule

// File: rtl/i2q2_scheduler.sv
// Round-robin scheduler time-sharing one I²+Q² squarer among tracking channels, three taps per grant.
module i2q2_scheduler
  import i2q2_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = 2,
  parameter int MAG_WIDTH    = 18,
  parameter int I2Q2_WIDTH   = i2q2_width(MAG_WIDTH),
  parameter int MULT_LATENCY = 5
) (
  input  logic                              clk,
  input  logic                              global_reset,
  input  logic [NUM_CHANNELS-1:0]           req,
  input  logic [NUM_CHANNELS*3*MAG_WIDTH-1:0] i_mag,
  input  logic [NUM_CHANNELS*3*MAG_WIDTH-1:0] q_mag,
  output logic [NUM_CHANNELS-1:0]           ack,
  output logic                              busy,
  output logic                              result_valid,
  output logic [CH_WIDTH-1:0]               result_channel,
  output logic [1:0]                        result_tap,
  output logic [I2Q2_WIDTH-1:0]             result_i2q2,
  output logic                              triple_done
);

  state_e               state, state_nxt;
  logic [CH_WIDTH-1:0]  rr_ptr, winner, hold_ch;
  logic                 grant_found, grant;
  logic [MAG_WIDTH-1:0] hold_i [3];
  logic [MAG_WIDTH-1:0] hold_q [3];
  logic                 issue_valid;
  tap_e                 issue_tap;
  logic                 pipe_busy;

  // NOTE: every combinational output gets a default before the search so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      if (!grant_found && req[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
        grant_found = 1'b1;
        winner      = CH_WIDTH'((int'(rr_ptr) + k) % NUM_CHANNELS);
      end
    end
  end

  assign grant = grant_found && (state == S_IDLE || state == S_ISSUE_L) && !global_reset;

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      state  <= S_IDLE;
      rr_ptr <= CH_WIDTH'(NUM_CHANNELS - 1);
    end else begin
      state <= state_nxt;
      if (grant) rr_ptr <= winner;
    end
  end

  // NOTE: holding registers carry no reset; nothing reads them until a grant has loaded them.
  always_ff @(posedge clk) begin
    if (grant) begin
      hold_ch <= winner;
      for (int t = 0; t < 3; t++) begin
        hold_i[t] <= i_mag[(int'(winner) * 3 + t) * MAG_WIDTH +: MAG_WIDTH];
        hold_q[t] <= q_mag[(int'(winner) * 3 + t) * MAG_WIDTH +: MAG_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_ISSUE_L: state_nxt = grant ? S_ISSUE_E : S_IDLE;
      S_ISSUE_E:         state_nxt = S_ISSUE_P;
      S_ISSUE_P:         state_nxt = S_ISSUE_L;
      default:           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack         = '0;
    issue_valid = 1'b0;
    issue_tap   = TAP_EARLY;
    if (grant) ack[winner] = 1'b1;
    unique case (state)
      S_ISSUE_E: begin issue_valid = 1'b1; issue_tap = TAP_EARLY;  end
      S_ISSUE_P: begin issue_valid = 1'b1; issue_tap = TAP_PROMPT; end
      S_ISSUE_L: begin issue_valid = 1'b1; issue_tap = TAP_LATE;   end
      default:   ;
    endcase
  end

  i2q2_square_pipe #(
    .MAG_WIDTH   (MAG_WIDTH),
    .MULT_LATENCY(MULT_LATENCY),
    .CH_WIDTH    (CH_WIDTH),
    .I2Q2_WIDTH  (I2Q2_WIDTH)
  ) u_square_pipe (
    .clk         (clk),
    .global_reset(global_reset),
    .in_valid    (issue_valid),
    .in_channel  (hold_ch),
    .in_tap      (issue_tap),
    .in_i        (hold_i[issue_tap]),
    .in_q        (hold_q[issue_tap]),
    .out_valid   (result_valid),
    .out_channel (result_channel),
    .out_tap     (result_tap),
    .out_i2q2    (result_i2q2),
    .pipe_busy   (pipe_busy)
  );

  assign busy        = (state != S_IDLE) || pipe_busy;
  assign triple_done = result_valid && (result_tap == TAP_LATE);

endmodule

// File: tb/tb_i2q2_scheduler.sv
// Self-checking bench: transaction-level round-robin/latency model plus directed scenarios and random traffic.
module tb_i2q2_scheduler;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int MW = 18;
  localparam int RW = 37;
  localparam int L  = 5;
  localparam int VW = N * 3 * MW;

  logic          clk = 1'b0;
  logic          global_reset;
  logic [N-1:0]  req;
  logic [VW-1:0] i_mag, q_mag;
  logic [N-1:0]  ack;
  logic          busy, result_valid, triple_done;
  logic [CW-1:0] result_channel;
  logic [1:0]    result_tap;
  logic [RW-1:0] result_i2q2;

  always #5 clk = ~clk;

  i2q2_scheduler dut (
    .clk           (clk),
    .global_reset  (global_reset),
    .req           (req),
    .i_mag         (i_mag),
    .q_mag         (q_mag),
    .ack           (ack),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_channel(result_channel),
    .result_tap    (result_tap),
    .result_i2q2   (result_i2q2),
    .triple_done   (triple_done)
  );

  typedef struct {int cyc; int ch; int tap; longint val; int done;} res_t;
  typedef struct {int cyc; int ch;} ack_t;

  res_t m_q[$];
  res_t res_log[$];
  ack_t ack_log[$];
  int   m_ptr = N - 1;
  int   m_left = 0;
  int   last_ack = -1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint mag_of(input logic [VW-1:0] v, input int ch, input int t);
    return longint'(v[(ch * 3 + t) * MW +: MW]);
  endfunction

  task automatic set_mag(input int ch, input int t, input int iv, input int qv);
    i_mag[(ch * 3 + t) * MW +: MW] = MW'(iv);
    q_mag[(ch * 3 + t) * MW +: MW] = MW'(qv);
  endtask

  // One clock cycle: compare outputs against the model, log observations, advance the model.
  task automatic tick();
    int            win;
    logic [N-1:0]  exp_ack;
    logic          exp_busy;
    longint        iv, qv;
    @(negedge clk);
    win = -1;
    exp_ack = '0;
    if (!global_reset && m_left <= 1) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && req[c]) win = c;
      end
    end
    if (win >= 0) exp_ack[win] = 1'b1;
    check("ack", 64'(ack), 64'(exp_ack));

    last_ack = -1;
    for (int c = 0; c < N; c++) if (ack[c]) last_ack = c;
    if (ack != '0) ack_log.push_back('{cyc, last_ack});
    if (result_valid)
      res_log.push_back('{cyc, int'(result_channel), int'(result_tap), longint'(result_i2q2), int'(triple_done)});

    if (!global_reset) begin
      exp_busy = (m_left > 0);
      foreach (m_q[j]) if (m_q[j].cyc - L - 1 <= cyc) exp_busy = 1'b1;
      check("busy", 64'(busy), 64'(exp_busy));
      if (m_q.size() > 0 && m_q[0].cyc == cyc) begin
        check("res_valid", 64'(result_valid), 64'd1);
        check("res_channel", 64'(result_channel), 64'(m_q[0].ch));
        check("res_tap", 64'(result_tap), 64'(m_q[0].tap));
        check("res_i2q2", 64'(result_i2q2), 64'(m_q[0].val));
        check("triple_done", 64'(triple_done), 64'(m_q[0].tap == 2));
        void'(m_q.pop_front());
      end else begin
        check("res_idle", 64'(result_valid), 64'd0);
        check("done_idle", 64'(triple_done), 64'd0);
      end
    end

    if (global_reset) begin
      m_q.delete();
      m_left = 0;
      m_ptr  = N - 1;
    end else if (win >= 0) begin
      for (int t = 0; t < 3; t++) begin
        iv = mag_of(i_mag, win, t);
        qv = mag_of(q_mag, win, t);
        m_q.push_back('{cyc + t + L + 2, win, t, iv * iv + qv * qv, int'(t == 2)});
      end
      m_ptr  = win;
      m_left = 3;
    end else if (m_left > 0) begin
      m_left--;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_drop(input int n);
    repeat (n) begin
      tick();
      if (last_ack >= 0) req[last_ack] = 1'b0;
    end
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    req = '0;
    tick();
    tick();
    global_reset = 1'b0;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_done", 64'(triple_done), 64'd0);
    check("rst_channel", 64'(result_channel), 64'd0);
    check("rst_tap", 64'(result_tap), 64'd0);
    check("rst_i2q2", 64'(result_i2q2), 64'd0);
    res_log.delete();
    ack_log.delete();
  endtask

  initial begin
    global_reset = 1'b1;
    req   = '0;
    i_mag = '0;
    q_mag = '0;
    #1;

    // Single request on channel 2.
    do_reset();
    set_mag(2, 0, 3, 4);
    set_mag(2, 1, 5, 12);
    set_mag(2, 2, 0, 7);
    req = 4'b0100;
    run_drop(14);
    check("s1_nack", ack_log.size(), 1);
    check("s1_nres", res_log.size(), 3);
    if (ack_log.size() == 1 && res_log.size() == 3) begin
      check("s1_ack_ch", ack_log[0].ch, 2);
      check("s1_e", res_log[0].val, 25);
      check("s1_p", res_log[1].val, 169);
      check("s1_l", res_log[2].val, 49);
      for (int t = 0; t < 3; t++) begin
        check("s1_ch", res_log[t].ch, 2);
        check("s1_tap", res_log[t].tap, t);
        check("s1_lat", res_log[t].cyc, ack_log[0].cyc + 7 + t);
        check("s1_done", res_log[t].done, (t == 2) ? 1 : 0);
      end
    end

    // Simultaneous requests from channels 0 and 1.
    do_reset();
    req = 4'b0011;
    run_drop(20);
    check("s2_nack", ack_log.size(), 2);
    check("s2_nres", res_log.size(), 6);
    if (ack_log.size() == 2 && res_log.size() == 6) begin
      check("s2_first", ack_log[0].ch, 0);
      check("s2_second", ack_log[1].ch, 1);
      check("s2_gap", ack_log[1].cyc - ack_log[0].cyc, 3);
      check("s2_nobubble", res_log[5].cyc - res_log[0].cyc, 5);
      for (int j = 0; j < 6; j++) check("s2_order", res_log[j].ch, j / 3);
    end

    // All requests held: strict rotation, one grant every 3 cycles.
    do_reset();
    req = 4'b1111;
    repeat (30) tick();
    req = '0;
    repeat (12) tick();
    check("s3_nack", ack_log.size(), 10);
    foreach (ack_log[j]) begin
      check("s3_rr", ack_log[j].ch, j % N);
      if (j > 0) check("s3_gap", ack_log[j].cyc - ack_log[j-1].cyc, 3);
    end

    // Maximum magnitudes.
    do_reset();
    for (int c = 0; c < N; c++)
      for (int t = 0; t < 3; t++) set_mag(c, t, 262143, 262143);
    req = 4'b0001;
    run_drop(14);
    check("s4_nres", res_log.size(), 3);
    foreach (res_log[j]) check("s4_max", res_log[j].val, 64'd137437904898);

    // Reset while one triple is in ISSUE_P and another is in flight.
    do_reset();
    for (int c = 0; c < N; c++)
      for (int t = 0; t < 3; t++) set_mag(c, t, int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)));
    req = 4'b0011;
    tick();
    req = 4'b0010;
    tick();
    tick();
    tick();
    req = '0;
    tick();
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    check("s5_busy_after_rst", 64'(busy), 64'd0);
    res_log.delete();
    ack_log.delete();
    req = 4'b1001;
    run_drop(20);
    check("s5_nres", res_log.size(), 6);
    if (ack_log.size() > 0) check("s5_first_grant", ack_log[0].ch, 0);
    else check("s5_no_grant", 0, 1);
    if (ack_log.size() > 0 && res_log.size() == 6) begin
      check("s5_first_res", res_log[0].cyc, ack_log[0].cyc + 7);
      for (int j = 0; j < 3; j++) check("s5_ch0", res_log[j].ch, 0);
    end

    // Magnitudes change right after ack; captured values must win.
    do_reset();
    set_mag(3, 0, 7, 24);
    set_mag(3, 1, 8, 15);
    set_mag(3, 2, 20, 21);
    req = 4'b1000;
    tick();
    req = '0;
    for (int t = 0; t < 3; t++) set_mag(3, t, 1000 + t, 2000 + t);
    repeat (12) tick();
    check("s6_nres", res_log.size(), 3);
    if (res_log.size() == 3) begin
      check("s6_e", res_log[0].val, 625);
      check("s6_p", res_log[1].val, 289);
      check("s6_l", res_log[2].val, 841);
    end

    // Random traffic with occasional resets and sticky requests.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      tick();
      global_reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        if (c == last_ack) req[c] = ($urandom_range(0, 7) == 0);
        else if (!req[c])  req[c] = ($urandom_range(0, 3) == 0);
      end
      for (int c = 0; c < N; c++)
        for (int t = 0; t < 3; t++) begin
          if ($urandom_range(0, 15) == 0) set_mag(c, t, 262143, 262143);
          else set_mag(c, t, int'($urandom & 32'h3ffff), int'($urandom & 32'h3ffff));
        end
    end
    global_reset = 1'b0;
    req = '0;
    repeat (15) tick();
    check("drain", m_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
